// File: rtl/hiscore_pkg.sv
// Shared types and default widths for the high-score RAM access sequencer.
package hiscore_pkg;

    localparam int HS_ADDR_WIDTH = 12;
    localparam int HS_DATA_WIDTH = 8;
    localparam int HS_CNT_WIDTH  = 4;

    typedef struct packed {
        logic                     write;
        logic [HS_ADDR_WIDTH-1:0] address;
        logic [HS_DATA_WIDTH-1:0] data;
    } hs_req_t;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCESS,
        RDWAIT,
        DONE
    } hs_state_t;

endpackage

// File: rtl/hiscore_access_ctrl_down_counter.sv
// Loadable down-counter with a zero flag; timebase for the settle and read-wait phases.
module down_counter
    import hiscore_pkg::*;
#(
    parameter int WIDTH = HS_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hiscore_access_ctrl.sv
// Pauses the core, takes the hs RAM port and performs one-byte host reads/writes,
// with back-to-back requests accepted in DONE so a burst settles only once.
//
// state  | meaning
// IDLE   | core running, port released, ready for a request
// SETTLE | core paused, address driven, waiting SETTLE_CYCLES
// ACCESS | write strobe (write) or read-wait counter load (read)
// RDWAIT | waiting READ_LATENCY cycles for hs_data_out; responds on the last one
// DONE   | write response; accepts a burst continuation or releases the core
module hiscore_access_ctrl
    import hiscore_pkg::*;
#(
    parameter int ADDR_WIDTH    = HS_ADDR_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [7:0]            req_wr_data,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rd_data,
    input  logic                  user_pause,
    output logic                  core_pause,
    output logic [ADDR_WIDTH-1:0] hs_address,
    output logic [7:0]            hs_data_in,
    input  logic [7:0]            hs_data_out,
    output logic                  hs_write_enable,
    output logic                  hs_access_write,
    output logic                  busy
);

    localparam logic [HS_CNT_WIDTH-1:0] SETTLE_LOAD = HS_CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [HS_CNT_WIDTH-1:0] RDWAIT_LOAD = HS_CNT_WIDTH'(READ_LATENCY - 1);

    hs_state_t               state;
    hs_state_t               state_next;
    hs_req_t                 req_q;
    logic [7:0]              rd_data_q;
    logic                    req_ready_q;
    logic                    accept;
    logic                    fsm_pause;
    logic                    rd_done;
    logic                    cnt_load;
    logic [HS_CNT_WIDTH-1:0] cnt_load_value;
    logic                    cnt_dec;
    logic                    cnt_zero;

    assign accept = req_valid && req_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = SETTLE;
            SETTLE:  if (cnt_zero) state_next = ACCESS;
            ACCESS:  state_next = req_q.write ? DONE : RDWAIT;
            RDWAIT:  if (cnt_zero) state_next = DONE;
            DONE:    state_next = accept ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fsm_pause       = 1'b0;
        hs_access_write = 1'b0;
        hs_write_enable = 1'b0;
        rd_done         = 1'b0;
        rsp_valid       = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_value  = SETTLE_LOAD;
        cnt_dec         = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_load = accept;
            end
            SETTLE: begin
                fsm_pause       = 1'b1;
                hs_access_write = 1'b1;
                cnt_dec         = 1'b1;
            end
            ACCESS: begin
                fsm_pause       = 1'b1;
                hs_access_write = 1'b1;
                hs_write_enable = req_q.write;
                cnt_load        = !req_q.write;
                cnt_load_value  = RDWAIT_LOAD;
            end
            RDWAIT: begin
                fsm_pause       = 1'b1;
                hs_access_write = 1'b1;
                cnt_dec         = 1'b1;
                rd_done         = cnt_zero;
                rsp_valid       = cnt_zero;
            end
            DONE: begin
                fsm_pause       = 1'b1;
                hs_access_write = 1'b1;
                rsp_valid       = req_q.write;
            end
            default: begin
                fsm_pause = 1'b0;
            end
        endcase
    end

    // Request fields are only sampled on accept, so the hs port stays stable for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q       <= '0;
            rd_data_q   <= '0;
            req_ready_q <= 1'b0;
        end else begin
            req_ready_q <= (state_next == IDLE) || (state_next == DONE);
            if (accept) begin
                req_q.write   <= req_write;
                req_q.address <= HS_ADDR_WIDTH'(req_address);
                req_q.data    <= req_wr_data;
            end
            if (rd_done) begin
                rd_data_q <= hs_data_out;
            end
        end
    end

    down_counter #(
        .WIDTH(HS_CNT_WIDTH)
    ) u_phase_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .decrement (cnt_dec),
        .zero      (cnt_zero)
    );

    // Read data is forwarded in the completing cycle and then held by rd_data_q.
    assign rsp_rd_data = rd_done ? hs_data_out : rd_data_q;
    assign req_ready   = req_ready_q;
    assign core_pause  = user_pause | fsm_pause;
    assign busy        = (state != IDLE);
    assign hs_address  = hs_access_write ? ADDR_WIDTH'(req_q.address) : '0;
    assign hs_data_in  = (hs_access_write && req_q.write) ? req_q.data : '0;

endmodule
